// File: rtl/gray_step_sequencer.sv
// gray_step_sequencer
//   Command-driven 2-bit Gray phase driver for quadrature/stepper outputs.
//   A move command (direction, step count, step period) is accepted over a
//   valid/ready handshake. The phase then advances one Gray step each period
//   until the count is exhausted or the move is aborted. A one-cycle done
//   pulse ends every move. phase and pos persist across moves.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   cmd_valid   in   command offered
//   cmd_ready   out  command can be accepted (IDLE only)
//   cmd_dir     in   1 = forward 00->01->11->10, 0 = reverse
//   cmd_steps   in   number of phase steps [CNT_W]
//   cmd_period  in   clock cycles per step, 0 treated as 1 [DIV_W]
//   abort       in   terminate the current move (sampled in RUN only)
//   phase       out  current Gray phase [2]
//   busy        out  move in progress
//   done        out  one-cycle completion pulse
//   aborted     out  high with done when the move was aborted
//   pos         out  signed-less modular position [CNT_W]
//   steps_left  out  steps remaining in the current move [CNT_W]
module gray_step_sequencer #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic [1:0]       phase,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] pos,
  output logic [CNT_W-1:0] steps_left
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] timer;
  logic [DIV_W-1:0] period_q;
  logic             dir_q;
  logic             accept;
  logic             abort_now;
  logic             step_now;

  // One Gray step in the requested direction.
  function automatic logic [1:0] gray_next(input logic [1:0] ph, input logic fwd);
    logic [1:0] nx;
    nx = ph;
    if (fwd) begin
      case (ph)
        2'b00: nx = 2'b01;
        2'b01: nx = 2'b11;
        2'b11: nx = 2'b10;
        default: nx = 2'b00;
      endcase
    end else begin
      case (ph)
        2'b00: nx = 2'b10;
        2'b10: nx = 2'b11;
        2'b11: nx = 2'b01;
        default: nx = 2'b00;
      endcase
    end
    return nx;
  endfunction

  // A zero period would never let the timer expire; run it as one cycle.
  function automatic logic [DIV_W-1:0] period_eff(input logic [DIV_W-1:0] p);
    return (p == '0) ? DIV_W'(1) : p;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign accept    = (state == IDLE) && cmd_valid;
  assign abort_now = (state == RUN) && abort;
  // Abort wins over a step that would fall on the same edge.
  assign step_now  = (state == RUN) && !abort && (timer == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid) state_nxt = (cmd_steps != '0) ? RUN : DONE;
      RUN: begin
        if (abort)                                       state_nxt = DONE;
        else if ((timer == '0) && (steps_left == CNT_W'(1))) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= 2'b00;
      pos        <= '0;
      steps_left <= '0;
      timer      <= '0;
      period_q   <= '0;
      dir_q      <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      done    <= (state_nxt == DONE);
      aborted <= abort_now;
      if (accept) begin
        dir_q      <= cmd_dir;
        period_q   <= period_eff(cmd_period);
        timer      <= period_eff(cmd_period) - DIV_W'(1);
        steps_left <= cmd_steps;
      end else if (step_now) begin
        phase      <= gray_next(phase, dir_q);
        pos        <= dir_q ? (pos + CNT_W'(1)) : (pos - CNT_W'(1));
        steps_left <= steps_left - CNT_W'(1);
        timer      <= period_q - DIV_W'(1);
      end else if ((state == RUN) && !abort) begin
        timer <= timer - DIV_W'(1);
      end
    end
  end

endmodule

// File: doc/gray_step_sequencer.md
# gray_step_sequencer

- Command-driven controller for the 2-bit Gray phase sequence 00→01→11→10, used as a quadrature/stepper phase driver.
- Accepts move commands (step count, direction, step period) over a valid/ready handshake and advances the phase one Gray step per period.
- Tracks position and remaining steps, supports abort, and signals completion with a one-cycle pulse.
- Sits between the control logic that issues moves and the phase outputs driving the actuator.

## Interface
Parameters:
- CNT_W, 16, width of step count, position and steps-remaining
- DIV_W, 16, width of step-period field

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command can be accepted; high only in IDLE
- cmd_dir  in  1  1 = forward (00→01→11→10→00), 0 = reverse
- cmd_steps  in  CNT_W  number of phase steps to take
- cmd_period  in  DIV_W  clock cycles per step; 0 is treated as 1
- abort  in  1  terminate current move
- phase  out  2  current Gray phase
- busy  out  1  high in RUN
- done  out  1  one-cycle completion pulse
- aborted  out  1  high together with done when the move was aborted
- pos  out  CNT_W  position, +1 per forward step, −1 per reverse step, modulo 2^CNT_W
- steps_left  out  CNT_W  steps remaining in the current move

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: cmd_ready=1. On an edge with cmd_valid=1, the block captures dir, steps and period (0→1), and loads steps_left=cmd_steps and timer=period−1.
  - steps ≠ 0 → RUN.
  - steps = 0 → DONE.
- RUN: timer decrements each cycle.
  - At an edge with timer=0: phase advances one Gray step in the captured direction, pos is updated by ±1, steps_left decrements, and timer reloads to period−1.
  - If that step makes steps_left 0 → DONE.
- DONE: lasts exactly one cycle with done=1, then → IDLE. aborted=1 in DONE only if entered via abort.
- Abort: only sampled in RUN.
  - At an edge with abort=1: → DONE with aborted set. No step is taken on that edge, even if timer=0 (abort has priority).
  - phase, pos and steps_left hold their values.
- abort in IDLE or DONE is ignored.
- cmd_valid outside IDLE is ignored. No command is queued.
- phase and pos persist across commands. Only rst returns them to 00 and 0.
- Reverse sequence: 00→10→11→01→00.
- pos wraps: 0 − 1 = 2^CNT_W − 1, and 2^CNT_W − 1 + 1 = 0.

## Timing
- Reset values (asynchronous, effective immediately, including mid-move):
  - state=IDLE, phase=00, pos=0, steps_left=0, busy=0, done=0, aborted=0.
  - cmd_ready=1 once reset deasserts.
  - timer and captured command registers are cleared.
- Let the accepting edge be E0, with N steps and period P.
  - Phase changes at edges E0+P, E0+2P, …, E0+N·P.
  - done is high in the cycle following E0+N·P.
  - cmd_ready returns high after E0+N·P+1.
- N=0: done is high in the cycle after E0, and phase is unchanged.
- Back-to-back throughput: a new command is accepted at the earliest one cycle after done.
- busy=1 exactly from the edge after E0 through edge E0+N·P; busy=0 while done is high.
- All outputs are registered except cmd_ready and busy, which are decoded from state.

## Test plan
- Reset: assert rst mid-cycle → immediately phase=00, pos=0, steps_left=0, busy=0, done=0, aborted=0; after release, cmd_ready=1.
- Forward move, steps=5, period=3 from phase 00 → phase 01,11,10,00,01 at E0+3,6,9,12,15; done pulses once after E0+15; pos=5, steps_left=0, aborted=0.
- Reverse move, steps=2, period=0 from phase 01, pos=5 → phase 00 at E0+1, 10 at E0+2; pos=3; done in the next cycle.
- Zero-step command → done one cycle after acceptance, phase and pos unchanged. Then reverse steps=1, period=1 from pos=0 → pos=0xFFFF (CNT_W=16).
- Abort: forward steps=10, period=4; abort asserted on the edge of the third step (timer=0) → only 2 steps taken, steps_left=8, phase held, done=1 and aborted=1 for one cycle.
- Command during busy: cmd_valid held high through a move → only one acceptance; the next command is accepted in the first IDLE cycle after done. Asserting rst mid-RUN aborts the move with all outputs at reset values.
